// File: rtl/mult_acc_stage.sv
// Saturating signed accumulation stage: sums each group of LEN products from the
// multiplier and presents the group result on a registered valid/ready port.
module mult_acc_stage #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     clr,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACC, HOLD} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic                     sat;

  logic signed [ACC_W:0]    ext;
  logic signed [ACC_W:0]    sum;
  logic                     pos_ovf;
  logic                     neg_ovf;
  logic signed [ACC_W-1:0]  clamped;

  // One guard bit above the accumulator holds any single-term sum exactly, so
  // overflow shows up as a disagreement between the top two bits.
  always_comb begin
    ext     = {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    sum     = {acc[ACC_W-1], acc} + ext;
    pos_ovf = !sum[ACC_W] &&  sum[ACC_W-1];
    neg_ovf =  sum[ACC_W] && !sum[ACC_W-1];
    clamped = sum[ACC_W-1:0];
    if (pos_ovf) clamped = MAX_V;
    if (neg_ovf) clamped = MIN_V;
  end

  assign in_ready = (state == ACC);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      acc_out   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      // Clear wins over both handshakes; acc_out keeps its last value.
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (cnt == LAST_CNT) begin
              acc_out   <= clamped;
              out_sat   <= sat | pos_ovf | neg_ovf;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              sat       <= 1'b0;
              state     <= HOLD;
            end else begin
              acc <= clamped;
              sat <= sat | pos_ovf | neg_ovf;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_acc_stage.sv
// Bench for mult_acc_stage: two instances (24-bit and 17-bit accumulators, LEN=4)
// share one directed stimulus stream; a group-sum model checks both every cycle.
module tb_mult_acc_stage;

  localparam int LEN = 4;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               clr = 1'b0;
  logic signed [15:0] prod_in = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;

  logic               in_ready_a, out_sat_a, out_valid_a;
  logic signed [23:0] acc_out_a;
  logic               in_ready_b, out_sat_b, out_valid_b;
  logic signed [16:0] acc_out_b;

  int n_pass  = 0;
  int n_total = 0;

  mult_acc_stage #(.PROD_W(16), .ACC_W(24), .LEN(LEN)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clr(clr), .prod_in(prod_in),
    .in_valid(in_valid), .in_ready(in_ready_a), .acc_out(acc_out_a),
    .out_sat(out_sat_a), .out_valid(out_valid_a), .out_ready(out_ready)
  );

  mult_acc_stage #(.PROD_W(16), .ACC_W(17), .LEN(LEN)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clr(clr), .prod_in(prod_in),
    .in_valid(in_valid), .in_ready(in_ready_b), .acc_out(acc_out_b),
    .out_sat(out_sat_b), .out_valid(out_valid_b), .out_ready(out_ready)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: plain integer group sums with clamping; index 0 = 24-bit, 1 = 17-bit.
  int     acc_w  [2] = '{24, 17};
  longint m_acc  [2] = '{0, 0};
  int     m_cnt  [2] = '{0, 0};
  bit     m_sat  [2] = '{0, 0};
  bit     m_pend [2] = '{0, 0};
  longint m_out  [2] = '{0, 0};
  bit     m_osat [2] = '{0, 0};

  always @(posedge sys_clk or negedge sys_rst_n) begin
    for (int i = 0; i < 2; i++) begin
      longint hi, lo, s;
      bit ov;
      hi = (64'sd1 <<< (acc_w[i] - 1)) - 1;
      lo = -(64'sd1 <<< (acc_w[i] - 1));
      if (!sys_rst_n) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
        m_pend[i] = 0; m_out[i] = 0; m_osat[i] = 0;
      end else if (clr) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0; m_pend[i] = 0;
      end else if (m_pend[i]) begin
        if (out_ready) m_pend[i] = 0;
      end else if (in_valid) begin
        s  = m_acc[i] + longint'(prod_in);
        ov = (s > hi) || (s < lo);
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        m_cnt[i]++;
        if (m_cnt[i] == LEN) begin
          m_out[i] = s; m_osat[i] = m_sat[i] | ov; m_pend[i] = 1;
          m_acc[i] = 0; m_sat[i] = 0; m_cnt[i] = 0;
        end else begin
          m_acc[i] = s; m_sat[i] = m_sat[i] | ov;
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      check("a_in_ready", longint'(in_ready_a), longint'(!m_pend[0]));
      check("a_out_valid", longint'(out_valid_a), longint'(m_pend[0]));
      check("b_in_ready", longint'(in_ready_b), longint'(!m_pend[1]));
      check("b_out_valid", longint'(out_valid_b), longint'(m_pend[1]));
      if (m_pend[0]) begin
        check("a_acc_out", longint'(acc_out_a), m_out[0]);
        check("a_out_sat", longint'(out_sat_a), longint'(m_osat[0]));
      end
      if (m_pend[1]) begin
        check("b_acc_out", longint'(acc_out_b), m_out[1]);
        check("b_out_sat", longint'(out_sat_b), longint'(m_osat[1]));
      end
    end
  end

  task automatic feed(input logic signed [15:0] p, input int gap);
    prod_in  = p;
    in_valid = 1'b1;
    @(negedge sys_clk);
    in_valid = 1'b0;
    prod_in  = 16'sd999;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic feed4(input logic signed [15:0] p);
    for (int k = 0; k < LEN; k++) feed(p, 0);
  endtask

  initial begin
    #12;
    check("rst_acc_out", longint'(acc_out_a), 0);
    check("rst_out_valid", longint'(out_valid_a), 0);
    check("rst_out_sat", longint'(out_sat_a), 0);
    check("rst_in_ready", longint'(in_ready_a), 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Back-to-back 4 x 16384; narrow instance clamps at +65535.
    feed4(16'sd16384);
    check("t1_valid", longint'(out_valid_a), 1);
    check("t1_in_ready", longint'(in_ready_a), 0);
    check("t1_acc_a", longint'(acc_out_a), 65536);
    check("t1_sat_a", longint'(out_sat_a), 0);
    check("t1_acc_b", longint'(acc_out_b), 65535);
    check("t1_sat_b", longint'(out_sat_b), 1);
    @(negedge sys_clk);
    check("t1_valid_drop", longint'(out_valid_a), 0);
    check("t1_in_ready_back", longint'(in_ready_a), 1);

    feed4(-16'sd16256);
    check("t1b_acc_b", longint'(acc_out_b), -65024);
    check("t1b_sat_b", longint'(out_sat_b), 0);
    check("t1b_acc_a", longint'(acc_out_a), -65024);
    @(negedge sys_clk);

    // Gapped stream.
    feed(16'sd16129, 2);
    feed(-16'sd16256, 2);
    feed(16'sd100, 2);
    feed(-16'sd1, 0);
    check("t2_valid", longint'(out_valid_a), 1);
    check("t2_acc_a", longint'(acc_out_a), -28);
    check("t2_acc_a_hex", longint'(acc_out_a[23:0]), 64'h00FF_FFE4);
    check("t2_sat_a", longint'(out_sat_a), 0);
    @(negedge sys_clk);

    // Backpressure: result held, offered products refused.
    out_ready = 1'b0;
    feed4(16'sd7);
    in_valid = 1'b1;
    prod_in  = 16'sd500;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      check("bp_valid", longint'(out_valid_a), 1);
      check("bp_acc", longint'(acc_out_a), 28);
      check("bp_in_ready", longint'(in_ready_a), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge sys_clk);
    check("bp_released", longint'(out_valid_a), 0);
    feed4(16'sd5);
    check("bp_next_group", longint'(acc_out_a), 20);
    @(negedge sys_clk);

    // Clear mid-group; the product offered with clr is discarded.
    feed(16'sd1000, 0);
    feed(16'sd2000, 0);
    clr      = 1'b1;
    in_valid = 1'b1;
    prod_in  = 16'sd3000;
    @(negedge sys_clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    feed4(16'sd10);
    check("clr_group", longint'(acc_out_a), 40);
    @(negedge sys_clk);

    // Clear during HOLD drops the pending result.
    out_ready = 1'b0;
    feed4(16'sd3);
    check("clr_hold_pre", longint'(out_valid_a), 1);
    check("clr_hold_acc", longint'(acc_out_a), 12);
    clr = 1'b1;
    @(negedge sys_clk);
    clr = 1'b0;
    check("clr_hold_valid", longint'(out_valid_a), 0);
    check("clr_hold_ready", longint'(in_ready_a), 1);
    out_ready = 1'b1;
    @(negedge sys_clk);

    // Asynchronous reset mid-group, checked before any clock edge.
    feed(16'sd50, 0);
    feed(16'sd50, 0);
    #1 sys_rst_n = 1'b0;
    #1;
    check("arst_acc_out", longint'(acc_out_a), 0);
    check("arst_out_valid", longint'(out_valid_a), 0);
    check("arst_out_sat", longint'(out_sat_a), 0);
    check("arst_in_ready", longint'(in_ready_a), 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    feed4(16'sd1);
    check("arst_after", longint'(acc_out_a), 4);
    check("arst_after_valid", longint'(out_valid_a), 1);

    repeat (3) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_acc_stage.md
# mult_acc_stage

Signed accumulation stage placed directly downstream of the 8x8 Booth/Wallace multiplier. It consumes the 16-bit signed product stream through a valid/ready handshake and sums each group of LEN products into an ACC_W-bit signed dot-product result. The sum saturates on overflow, and the result is presented on a registered valid/ready output port. This turns the combinational multiplier into a streaming MAC for filter and dot-product datapaths.

## Interface
- PROD_W, 16: product width; equals the multiplier output width.
- ACC_W, 24: accumulator and result width; must satisfy ACC_W >= PROD_W+1.
- LEN, 8: products per group; must be >= 1. Counter width is clog2(LEN), minimum 1.
- sys_clk  in  1  single clock; all state updates on its rising edge.
- sys_rst_n  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous clear; abandons the current group.
- prod_in  in  PROD_W  signed product; driven by the multiplier C_NUM.
- in_valid  in  1  prod_in is valid.
- in_ready  out  1  stage accepts a product this cycle.
- acc_out  out  ACC_W  signed group sum, registered.
- out_sat  out  1  saturation occurred within this group.
- out_valid  out  1  acc_out/out_sat valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- States: ACC (collecting) and HOLD (result pending). Reset state is ACC.
- in_ready = (state == ACC). It is decoded from registered state only, with no combinational path from out_ready.
- Accept: in_valid && in_ready at a rising edge.
- Each accept does the following:
  - sign-extend prod_in to ACC_W+1 bits;
  - nxt = acc + ext;
  - if nxt > 2^(ACC_W-1)-1, clamp to max and set sat;
  - if nxt < -2^(ACC_W-1), clamp to min and set sat;
  - acc = clamped value; cnt = cnt+1.
- Saturation is not wrap-around. Later terms continue from the clamped value, so the sum can leave the clamp.
- Final accept (cnt == LEN-1):
  - acc_out = clamped sum; out_sat = sat | this-term overflow; out_valid = 1;
  - acc = 0, sat = 0, cnt = 0; state goes to HOLD.
- HOLD:
  - acc_out and out_sat are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid = 0 and state returns to ACC. in_ready is high the following cycle.
- in_valid low cycles (gaps) leave acc, cnt and sat unchanged.
- clr = 1 at an edge:
  - acc = 0, cnt = 0, sat = 0; any product presented in that cycle is discarded (not accepted);
  - in HOLD, also out_valid = 0 and state = ACC, so the pending result is dropped;
  - clr has priority over every handshake.
- LEN = 1: every accept produces a result.

## Timing
- Reset (sys_rst_n low, asynchronous): acc_out = 0, out_sat = 0, out_valid = 0, acc = 0, cnt = 0, sat = 0, state = ACC, in_ready = 1.
- Reset mid-group or mid-HOLD discards everything immediately, without waiting for a clock edge.
- Latency: out_valid rises at the same edge that accepts the LEN-th product.
- Throughput: LEN+1 cycles per group minimum, because HOLD lasts at least one cycle.
- The multiplier is combinational, so prod_in must be settled before the sampling edge.

## Test plan
- Defaults (ACC_W=24, LEN=4); 4 products of 16384 (-128*-128), back-to-back, out_ready=1 -> acc_out=65536, out_sat=0.
  - out_valid is high for exactly 1 cycle.
  - in_ready is low for exactly 1 cycle.
- LEN=4; products 16129 (127*127), -16256 (-128*127), 100, -1, with 2-cycle in_valid gaps between them -> acc_out=-28 (0xFFFFE4), out_sat=0.
- ACC_W=17, LEN=4; 4 x 16384 -> acc_out=65535, out_sat=1.
  - Next group 4 x (-16256) -> acc_out=-65024, out_sat=0, showing sat is cleared between groups.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_valid held, acc_out unchanged, in_ready=0, in_valid products not accepted.
  - out_ready=1 -> handshake completes; next group starts from acc=0.
- clr after 2 accepted products (1000, 2000) -> then 4 products of 10 -> acc_out=40.
  - A product presented in the clr cycle is not counted.
  - clr during HOLD drops out_valid the next cycle.
- Assert sys_rst_n low mid-group without a clock edge -> all outputs 0 and in_ready=1 immediately.
  - After release, 4 products of 1 -> acc_out=4.
